decode_queue: RTL and testbench
===============================

DECODE_QUEUE -- requirements
Module: decode_queue

Interface
REQ-001 SHALL expose parameter FETCH_W, default 2, meaning instructions offered per fetch beat (1 or 2).
REQ-002 SHALL expose parameter ISSUE_W, default 2, meaning maximum decoded instructions presented per cycle (1 or 2).
REQ-003 SHALL expose parameter DEPTH, default 8, meaning queue entries (power of 2, >= 2*FETCH_W).
REQ-004 SHALL have ports:
clk  in  1  single clock; all state on rising edge
resetn  in  1  asynchronous, active-low reset
flush_i  in  1  discard all queued and presented instructions
fetch_valid_i  in  FETCH_W  per-slot instruction valid; slot 0 is oldest
fetch_instr_i  in  32*FETCH_W  instruction words, slot k at [32k+31:32k]
fetch_pc_i  in  32*FETCH_W  PCs, same packing
fetch_ready_o  out  1  queue accepts a fetch beat this cycle
dec_valid_o  out  ISSUE_W  per-slot decoded instruction valid
dec_pc_o  out  32*ISSUE_W  PC per issue slot
dec_instr_o  out  32*ISSUE_W  raw instruction per issue slot
dec_ctrl_o  out  CTRL_W*ISSUE_W  packed control word per slot (package struct)
dec_invalid_o  out  ISSUE_W  reserved-instruction flag per slot
dec_ready_i  in  1  consumer takes all valid issue slots this cycle
count_o  out  log2(DEPTH)+1  current occupancy

Function
REQ-005 SHALL accept a fetch beat when fetch_ready_o and any fetch_valid_i bit are high; fetch_valid_i SHALL be contiguous from slot 0.
REQ-006 SHALL drive fetch_ready_o high iff DEPTH - count >= FETCH_W, from registered count only (no same-cycle pop credit).
REQ-007 SHALL write accepted slots in order at the write pointer; pointers wrap modulo DEPTH.
REQ-008 SHALL present the oldest entries at issue slots 0..ISSUE_W-1; an entry written in cycle t SHALL be visible no earlier than cycle t+1.
REQ-009 dec_valid_o[k] SHALL be high iff count > k, subject to REQ-010.
REQ-010 With ISSUE_W=2, slot 1 SHALL be suppressed when slot 0 is a branch or jump (delay slot issues alone next cycle) or when both slots access HI/LO, CP0 or memory.
REQ-011 dec_ctrl_o and dec_invalid_o SHALL be combinational decodes of the presented entries; undecodable opcodes SHALL still issue with dec_invalid_o=1 and an all-zero control word.
REQ-012 On dec_ready_i high, SHALL pop exactly popcount(dec_valid_o) entries; dec_ready_i with no valid slot SHALL have no effect.
REQ-013 Simultaneous push and pop SHALL update count by pushed minus popped in one cycle.
REQ-014 flush_i SHALL take priority over push and pop in the same cycle: next-cycle count=0, pointers equal, dec_valid_o=0, no fetch beat accepted.
REQ-015 count_o SHALL never exceed DEPTH; pop never exceeds count.

Reset
REQ-016 resetn low SHALL asynchronously clear read pointer, write pointer and count; dec_valid_o=0, fetch_ready_o=1 during and after reset.
REQ-017 Reset mid-operation SHALL discard all entries; entry storage need not be cleared.

Structure
REQ-018 Opcode/function/rt/rs constants, CTRL_W and the control-word struct (wreg, regdst, use_imm, branch, jump, jal, jr, bal, jalr, rmem, wmem, memen, whilo[1:0], wcp0, alucontrol[4:0]) SHALL live in the shared decode package.
REQ-019 SHALL instantiate one purely combinational sub-module decode_slot per issue slot (instruction in, control word plus invalid out).

Verification
REQ-020 Reset, then push ORI/ADDU pair (FETCH_W=2) -> next cycle dec_valid_o=2'b11, count_o=2, dec_invalid_o=0.
REQ-021 Push BEQ+delay-slot ADDIU -> cycle 1 only slot 0 valid (BEQ); after pop, ADDIU alone in slot 0.
REQ-022 Fill to 8 with dec_ready_i=0 -> fetch_ready_o=0 at count 7 and 8; pop 2 -> fetch_ready_o=1 next cycle.
REQ-023 count=5, push 2 and pop 2 same cycle -> count_o stays 5, order preserved across pointer wrap.
REQ-024 flush_i with push and dec_ready_i high, count=6 -> next cycle count_o=0, dec_valid_o=0.
REQ-025 Push opcode 6'b111111 -> issued with dec_invalid_o=1, control word 0; resetn low mid-burst -> count_o=0 immediately.

Source files
------------

// File: rtl/decode_queue_pkg.sv
// Shared decode definitions: MIPS opcode/function constants, ALU op encoding,
// the per-slot control word and the dual-issue pairing rule.
package decode_queue_pkg;

  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] OP_REGIMM  = 6'b000001;
  localparam logic [5:0] OP_J       = 6'b000010;
  localparam logic [5:0] OP_JAL     = 6'b000011;
  localparam logic [5:0] OP_BEQ     = 6'b000100;
  localparam logic [5:0] OP_BNE     = 6'b000101;
  localparam logic [5:0] OP_BLEZ    = 6'b000110;
  localparam logic [5:0] OP_BGTZ    = 6'b000111;
  localparam logic [5:0] OP_ADDI    = 6'b001000;
  localparam logic [5:0] OP_ADDIU   = 6'b001001;
  localparam logic [5:0] OP_SLTI    = 6'b001010;
  localparam logic [5:0] OP_SLTIU   = 6'b001011;
  localparam logic [5:0] OP_ANDI    = 6'b001100;
  localparam logic [5:0] OP_ORI     = 6'b001101;
  localparam logic [5:0] OP_XORI    = 6'b001110;
  localparam logic [5:0] OP_LUI     = 6'b001111;
  localparam logic [5:0] OP_COP0    = 6'b010000;
  localparam logic [5:0] OP_LB      = 6'b100000;
  localparam logic [5:0] OP_LH      = 6'b100001;
  localparam logic [5:0] OP_LW      = 6'b100011;
  localparam logic [5:0] OP_LBU     = 6'b100100;
  localparam logic [5:0] OP_LHU     = 6'b100101;
  localparam logic [5:0] OP_SB      = 6'b101000;
  localparam logic [5:0] OP_SH      = 6'b101001;
  localparam logic [5:0] OP_SW      = 6'b101011;

  localparam logic [5:0] F_SLL   = 6'b000000;
  localparam logic [5:0] F_SRL   = 6'b000010;
  localparam logic [5:0] F_SRA   = 6'b000011;
  localparam logic [5:0] F_SLLV  = 6'b000100;
  localparam logic [5:0] F_SRLV  = 6'b000110;
  localparam logic [5:0] F_SRAV  = 6'b000111;
  localparam logic [5:0] F_JR    = 6'b001000;
  localparam logic [5:0] F_JALR  = 6'b001001;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTLO  = 6'b010011;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_ADD   = 6'b100000;
  localparam logic [5:0] F_ADDU  = 6'b100001;
  localparam logic [5:0] F_SUB   = 6'b100010;
  localparam logic [5:0] F_SUBU  = 6'b100011;
  localparam logic [5:0] F_AND   = 6'b100100;
  localparam logic [5:0] F_OR    = 6'b100101;
  localparam logic [5:0] F_XOR   = 6'b100110;
  localparam logic [5:0] F_NOR   = 6'b100111;
  localparam logic [5:0] F_SLT   = 6'b101010;
  localparam logic [5:0] F_SLTU  = 6'b101011;
  localparam logic [5:0] F_ERET  = 6'b011000;

  localparam logic [4:0] RT_BLTZ   = 5'b00000;
  localparam logic [4:0] RT_BGEZ   = 5'b00001;
  localparam logic [4:0] RT_BLTZAL = 5'b10000;
  localparam logic [4:0] RT_BGEZAL = 5'b10001;

  localparam logic [4:0] RS_MF = 5'b00000;
  localparam logic [4:0] RS_MT = 5'b00100;
  localparam logic [4:0] RS_CO = 5'b10000;

  typedef enum logic [4:0] {
    ALU_NOP, ALU_ADD, ALU_ADDU, ALU_SUB, ALU_SUBU, ALU_AND, ALU_OR, ALU_XOR,
    ALU_NOR, ALU_SLT, ALU_SLTU, ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLLV, ALU_SRLV,
    ALU_SRAV, ALU_LUI, ALU_MULT, ALU_MULTU, ALU_DIV, ALU_DIVU, ALU_MFHI,
    ALU_MFLO, ALU_MTHI, ALU_MTLO, ALU_MFC0, ALU_MTC0, ALU_ERET
  } alu_op_e;

  typedef struct packed {
    logic       wreg;
    logic       regdst;
    logic       use_imm;
    logic       branch;
    logic       jump;
    logic       jal;
    logic       jr;
    logic       bal;
    logic       jalr;
    logic       rmem;
    logic       wmem;
    logic       memen;
    logic [1:0] whilo;
    logic       wcp0;
    alu_op_e    alucontrol;
  } ctrl_t;

  localparam int unsigned CTRL_W = $bits(ctrl_t);

  function automatic alu_op_e rtype_alu(input logic [5:0] funct);
    case (funct)
      F_SLL:   return ALU_SLL;
      F_SRL:   return ALU_SRL;
      F_SRA:   return ALU_SRA;
      F_SLLV:  return ALU_SLLV;
      F_SRLV:  return ALU_SRLV;
      F_SRAV:  return ALU_SRAV;
      F_MFHI:  return ALU_MFHI;
      F_MFLO:  return ALU_MFLO;
      F_MULT:  return ALU_MULT;
      F_MULTU: return ALU_MULTU;
      F_DIV:   return ALU_DIV;
      F_DIVU:  return ALU_DIVU;
      F_ADD:   return ALU_ADD;
      F_ADDU:  return ALU_ADDU;
      F_SUB:   return ALU_SUB;
      F_SUBU:  return ALU_SUBU;
      F_AND:   return ALU_AND;
      F_OR:    return ALU_OR;
      F_XOR:   return ALU_XOR;
      F_NOR:   return ALU_NOR;
      F_SLT:   return ALU_SLT;
      F_SLTU:  return ALU_SLTU;
      default: return ALU_NOP;
    endcase
  endfunction

  function automatic alu_op_e itype_alu(input logic [5:0] op);
    case (op)
      OP_ADDI:  return ALU_ADD;
      OP_ADDIU: return ALU_ADDU;
      OP_SLTI:  return ALU_SLT;
      OP_SLTIU: return ALU_SLTU;
      OP_ANDI:  return ALU_AND;
      OP_ORI:   return ALU_OR;
      OP_XORI:  return ALU_XOR;
      OP_LUI:   return ALU_LUI;
      default:  return ALU_NOP;
    endcase
  endfunction

  function automatic logic uses_hilo(input ctrl_t c);
    return (c.whilo != 2'b00) || (c.alucontrol == ALU_MFHI) || (c.alucontrol == ALU_MFLO);
  endfunction

  function automatic logic uses_cp0(input ctrl_t c);
    return c.wcp0 || (c.alucontrol == ALU_MFC0) || (c.alucontrol == ALU_ERET);
  endfunction

  // Slot 1 must wait when slot 0 redirects flow (its delay slot issues alone)
  // or when both slots would contend for the same single-ported resource.
  function automatic logic pair_conflict(input ctrl_t s0, input ctrl_t s1);
    return s0.branch || s0.jump ||
           (uses_hilo(s0) && uses_hilo(s1)) ||
           (uses_cp0(s0) && uses_cp0(s1)) ||
           (s0.memen && s1.memen);
  endfunction

endpackage

// File: rtl/decode_queue_slot.sv
// Combinational MIPS decoder for one issue slot; unknown encodings raise
// invalid_o and leave the control word all-zero.
module decode_slot
  import decode_queue_pkg::*;
(
  input  logic [31:0] instr_i,
  output ctrl_t       ctrl_o,
  output logic        invalid_o
);

  logic [5:0] op;
  logic [5:0] funct;
  logic [4:0] rs;
  logic [4:0] rt;
  logic       unused_fields;

  assign op            = instr_i[31:26];
  assign rs            = instr_i[25:21];
  assign rt            = instr_i[20:16];
  assign funct         = instr_i[5:0];
  assign unused_fields = ^instr_i[15:6];

  always_comb begin
    ctrl_o    = '0;
    invalid_o = 1'b0;
    case (op)
      OP_SPECIAL: begin
        case (funct)
          F_SLL, F_SRL, F_SRA, F_SLLV, F_SRLV, F_SRAV, F_MFHI, F_MFLO,
          F_ADD, F_ADDU, F_SUB, F_SUBU, F_AND, F_OR, F_XOR, F_NOR,
          F_SLT, F_SLTU: begin
            ctrl_o.wreg       = 1'b1;
            ctrl_o.regdst     = 1'b1;
            ctrl_o.alucontrol = rtype_alu(funct);
          end
          F_JR: begin
            ctrl_o.jump = 1'b1;
            ctrl_o.jr   = 1'b1;
          end
          F_JALR: begin
            ctrl_o.jump   = 1'b1;
            ctrl_o.jr     = 1'b1;
            ctrl_o.jalr   = 1'b1;
            ctrl_o.wreg   = 1'b1;
            ctrl_o.regdst = 1'b1;
          end
          F_MTHI: begin
            ctrl_o.whilo      = 2'b10;
            ctrl_o.alucontrol = ALU_MTHI;
          end
          F_MTLO: begin
            ctrl_o.whilo      = 2'b01;
            ctrl_o.alucontrol = ALU_MTLO;
          end
          F_MULT, F_MULTU, F_DIV, F_DIVU: begin
            ctrl_o.whilo      = 2'b11;
            ctrl_o.alucontrol = rtype_alu(funct);
          end
          default: invalid_o = 1'b1;
        endcase
      end
      OP_REGIMM: begin
        case (rt)
          RT_BLTZ, RT_BGEZ: begin
            ctrl_o.branch     = 1'b1;
            ctrl_o.alucontrol = ALU_SUBU;
          end
          RT_BLTZAL, RT_BGEZAL: begin
            ctrl_o.branch     = 1'b1;
            ctrl_o.bal        = 1'b1;
            ctrl_o.wreg       = 1'b1;
            ctrl_o.alucontrol = ALU_SUBU;
          end
          default: invalid_o = 1'b1;
        endcase
      end
      OP_J: ctrl_o.jump = 1'b1;
      OP_JAL: begin
        ctrl_o.jump = 1'b1;
        ctrl_o.jal  = 1'b1;
        ctrl_o.wreg = 1'b1;
      end
      OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: begin
        ctrl_o.branch     = 1'b1;
        ctrl_o.alucontrol = ALU_SUBU;
      end
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
        ctrl_o.wreg       = 1'b1;
        ctrl_o.use_imm    = 1'b1;
        ctrl_o.alucontrol = itype_alu(op);
      end
      OP_COP0: begin
        if (rs == RS_MF) begin
          ctrl_o.wreg       = 1'b1;
          ctrl_o.alucontrol = ALU_MFC0;
        end else if (rs == RS_MT) begin
          ctrl_o.wcp0       = 1'b1;
          ctrl_o.alucontrol = ALU_MTC0;
        end else if (rs == RS_CO && funct == F_ERET) begin
          ctrl_o.alucontrol = ALU_ERET;
        end else begin
          invalid_o = 1'b1;
        end
      end
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: begin
        ctrl_o.wreg       = 1'b1;
        ctrl_o.use_imm    = 1'b1;
        ctrl_o.rmem       = 1'b1;
        ctrl_o.memen      = 1'b1;
        ctrl_o.alucontrol = ALU_ADDU;
      end
      OP_SB, OP_SH, OP_SW: begin
        ctrl_o.use_imm    = 1'b1;
        ctrl_o.wmem       = 1'b1;
        ctrl_o.memen      = 1'b1;
        ctrl_o.alucontrol = ALU_ADDU;
      end
      default: invalid_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/decode_queue.sv
// Circular instruction queue between fetch and issue; presents the oldest
// entries decoded, with dual-issue pairing restrictions on slot 1.
module decode_queue
  import decode_queue_pkg::*;
#(
  parameter int unsigned FETCH_W = 2,
  parameter int unsigned ISSUE_W = 2,
  parameter int unsigned DEPTH   = 8
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic                        flush_i,
  input  logic [FETCH_W-1:0]          fetch_valid_i,
  input  logic [32*FETCH_W-1:0]       fetch_instr_i,
  input  logic [32*FETCH_W-1:0]       fetch_pc_i,
  output logic                        fetch_ready_o,
  output logic [ISSUE_W-1:0]          dec_valid_o,
  output logic [32*ISSUE_W-1:0]       dec_pc_o,
  output logic [32*ISSUE_W-1:0]       dec_instr_o,
  output logic [CTRL_W*ISSUE_W-1:0]   dec_ctrl_o,
  output logic [ISSUE_W-1:0]          dec_invalid_o,
  input  logic                        dec_ready_i,
  output logic [$clog2(DEPTH):0]      count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [31:0]   instr_mem_q [DEPTH];
  logic [31:0]   pc_mem_q    [DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] push_n, pop_n;
  logic          push;
  logic          pair_block;
  ctrl_t         slot_ctrl [ISSUE_W];
  logic [ISSUE_W-1:0] slot_inv;

  // Space is judged from the registered count only; a same-cycle pop frees nothing.
  assign fetch_ready_o = (CW'(DEPTH) - count_q) >= CW'(FETCH_W);
  assign push          = fetch_ready_o & (|fetch_valid_i) & ~flush_i;
  assign count_o       = count_q;

  for (genvar k = 0; k < ISSUE_W; k++) begin : g_slot
    logic [AW-1:0] idx;
    assign idx                         = rd_ptr_q + AW'(k);
    assign dec_instr_o[32*k +: 32]     = instr_mem_q[idx];
    assign dec_pc_o[32*k +: 32]        = pc_mem_q[idx];
    assign dec_ctrl_o[CTRL_W*k +: CTRL_W] = slot_ctrl[k];
    assign dec_invalid_o[k]            = slot_inv[k];
    assign dec_valid_o[k]              = (count_q > CW'(k)) && !((k == 1) && pair_block);

    decode_slot u_decode_slot (
      .instr_i   (instr_mem_q[idx]),
      .ctrl_o    (slot_ctrl[k]),
      .invalid_o (slot_inv[k])
    );
  end

  if (ISSUE_W > 1) begin : g_pair
    assign pair_block = pair_conflict(slot_ctrl[0], slot_ctrl[1]);
  end else begin : g_single
    assign pair_block = 1'b0;
  end

  always_comb begin
    push_n = '0;
    pop_n  = '0;
    for (int unsigned k = 0; k < FETCH_W; k++) begin
      push_n = push_n + CW'(fetch_valid_i[k]);
    end
    if (!push) begin
      push_n = '0;
    end
    if (dec_ready_i) begin
      for (int unsigned k = 0; k < ISSUE_W; k++) begin
        pop_n = pop_n + CW'(dec_valid_o[k]);
      end
    end
    rd_ptr_d = rd_ptr_q + AW'(pop_n);
    wr_ptr_d = wr_ptr_q + AW'(push_n);
    count_d  = count_q + push_n - pop_n;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end
  end

  // Entry storage is not reset; count gating keeps stale words invisible.
  always_ff @(posedge clk) begin
    if (push) begin
      for (int unsigned k = 0; k < FETCH_W; k++) begin
        if (fetch_valid_i[k]) begin
          instr_mem_q[wr_ptr_q + AW'(k)] <= fetch_instr_i[32*k +: 32];
          pc_mem_q[wr_ptr_q + AW'(k)]    <= fetch_pc_i[32*k +: 32];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: tb/tb_decode_queue.sv
// Randomized and directed bench for decode_queue against a queue-based
// reference model driven by an instruction-class table.
module tb_decode_queue;
  import decode_queue_pkg::*;

  localparam int FW = 2;
  localparam int IW = 2;
  localparam int DP = 8;

  localparam int T_ADDU = 0, T_ORI = 1, T_ADDIU = 2, T_BEQ = 3, T_J = 4,
                 T_JAL = 5, T_JR = 6, T_LW = 7, T_SW = 8, T_MULT = 9,
                 T_MFHI = 10, T_MTC0 = 11, T_MFC0 = 12, T_INV = 13, T_SLL = 14;
  localparam int NT = 15;

  typedef struct {
    logic [31:0] base;
    logic [31:0] mask;
    bit cti, hilo, cp0, mem, wreg, inv;
  } tmpl_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    int          t;
  } ent_t;

  logic                 clk = 1'b0;
  logic                 resetn = 1'b1;
  logic                 flush_i = 1'b0;
  logic [FW-1:0]        fetch_valid_i = '0;
  logic [32*FW-1:0]     fetch_instr_i = '0;
  logic [32*FW-1:0]     fetch_pc_i = '0;
  logic                 fetch_ready_o;
  logic [IW-1:0]        dec_valid_o;
  logic [32*IW-1:0]     dec_pc_o;
  logic [32*IW-1:0]     dec_instr_o;
  logic [CTRL_W*IW-1:0] dec_ctrl_o;
  logic [IW-1:0]        dec_invalid_o;
  logic                 dec_ready_i = 1'b0;
  logic [$clog2(DP):0]  count_o;

  tmpl_t       tbl [NT];
  ent_t        q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] pc_n = 32'h0000_1000;

  always #5 clk = ~clk;

  decode_queue #(.FETCH_W(FW), .ISSUE_W(IW), .DEPTH(DP)) dut (
    .clk           (clk),
    .resetn        (resetn),
    .flush_i       (flush_i),
    .fetch_valid_i (fetch_valid_i),
    .fetch_instr_i (fetch_instr_i),
    .fetch_pc_i    (fetch_pc_i),
    .fetch_ready_o (fetch_ready_o),
    .dec_valid_o   (dec_valid_o),
    .dec_pc_o      (dec_pc_o),
    .dec_instr_o   (dec_instr_o),
    .dec_ctrl_o    (dec_ctrl_o),
    .dec_invalid_o (dec_invalid_o),
    .dec_ready_i   (dec_ready_i),
    .count_o       (count_o)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mk(input int t);
    return tbl[t].base | ($urandom & tbl[t].mask);
  endfunction

  function automatic bit conflict(input int a, input int b);
    return tbl[a].cti || (tbl[a].hilo && tbl[b].hilo) ||
           (tbl[a].cp0 && tbl[b].cp0) || (tbl[a].mem && tbl[b].mem);
  endfunction

  task automatic check_state(output bit rdy_e, output logic [1:0] ev);
    int    sz;
    ctrl_t c;
    sz    = q.size();
    rdy_e = (DP - sz) >= FW;
    ev[0] = sz > 0;
    ev[1] = (sz > 1) && !conflict(q[0].t, q[1].t);
    chk("count", 64'(count_o), 64'(sz));
    chk("fetch_ready", 64'(fetch_ready_o), 64'(rdy_e));
    chk("dec_valid", 64'(dec_valid_o), 64'(ev));
    for (int k = 0; k < IW; k++) begin
      if (ev[k]) begin
        c = ctrl_t'(dec_ctrl_o[k*CTRL_W +: CTRL_W]);
        chk($sformatf("pc%0d", k), 64'(dec_pc_o[32*k +: 32]), 64'(q[k].pc));
        chk($sformatf("instr%0d", k), 64'(dec_instr_o[32*k +: 32]), 64'(q[k].instr));
        chk($sformatf("invalid%0d", k), 64'(dec_invalid_o[k]), 64'(tbl[q[k].t].inv));
        chk($sformatf("cti%0d", k), 64'(c.branch | c.jump), 64'(tbl[q[k].t].cti));
        chk($sformatf("memen%0d", k), 64'(c.memen), 64'(tbl[q[k].t].mem));
        chk($sformatf("wreg%0d", k), 64'(c.wreg), 64'(tbl[q[k].t].wreg));
        if (tbl[q[k].t].inv) chk($sformatf("inv_ctrl%0d", k), 64'(c), 64'(0));
      end
    end
  endtask

  task automatic step(input bit fl, input int nv, input int t0, input int t1, input bit rdy);
    logic [31:0] w0, w1;
    bit          rdy_e;
    logic [1:0]  ev;
    int          npop;
    ent_t        e;
    @(negedge clk);
    w0            = mk(t0);
    w1            = mk(t1);
    flush_i       = fl;
    fetch_valid_i = (nv == 0) ? 2'b00 : (nv == 1) ? 2'b01 : 2'b11;
    fetch_instr_i = {w1, w0};
    fetch_pc_i    = {pc_n + 32'd4, pc_n};
    dec_ready_i   = rdy;
    #1;
    check_state(rdy_e, ev);
    if (fl) begin
      q.delete();
    end else begin
      npop = rdy ? (int'(ev[0]) + int'(ev[1])) : 0;
      repeat (npop) void'(q.pop_front());
      if (rdy_e && nv > 0) begin
        e.pc = pc_n; e.instr = w0; e.t = t0;
        q.push_back(e);
        if (nv == 2) begin
          e.pc = pc_n + 32'd4; e.instr = w1; e.t = t1;
          q.push_back(e);
        end
        pc_n += 32'(4 * nv);
      end
    end
    @(posedge clk);
    #1;
    flush_i       = 1'b0;
    fetch_valid_i = '0;
    dec_ready_i   = 1'b0;
  endtask

  task automatic peek(input string tag, input int cnt, input logic [1:0] v,
                      input logic [1:0] inv, input bit rdy);
    @(negedge clk);
    #1;
    chk({tag, "_count"}, 64'(count_o), 64'(cnt));
    chk({tag, "_valid"}, 64'(dec_valid_o), 64'(v));
    chk({tag, "_invalid"}, 64'(dec_invalid_o & dec_valid_o), 64'(inv));
    chk({tag, "_ready"}, 64'(fetch_ready_o), 64'(rdy));
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    resetn        = 1'b0;
    fetch_valid_i = 2'b11;
    dec_ready_i   = 1'b1;
    #1;
    chk({tag, "_count"}, 64'(count_o), 64'(0));
    chk({tag, "_ready"}, 64'(fetch_ready_o), 64'(1));
    chk({tag, "_valid"}, 64'(dec_valid_o), 64'(0));
    q.delete();
    @(posedge clk);
    #1;
    chk({tag, "_count_held"}, 64'(count_o), 64'(0));
    fetch_valid_i = '0;
    dec_ready_i   = 1'b0;
    resetn        = 1'b1;
  endtask

  initial begin
    tbl[T_ADDU]  = '{32'h0000_0021, 32'h03FF_F800, 0, 0, 0, 0, 1, 0};
    tbl[T_ORI]   = '{32'h3400_0000, 32'h03FF_FFFF, 0, 0, 0, 0, 1, 0};
    tbl[T_ADDIU] = '{32'h2400_0000, 32'h03FF_FFFF, 0, 0, 0, 0, 1, 0};
    tbl[T_BEQ]   = '{32'h1000_0000, 32'h03FF_FFFF, 1, 0, 0, 0, 0, 0};
    tbl[T_J]     = '{32'h0800_0000, 32'h03FF_FFFF, 1, 0, 0, 0, 0, 0};
    tbl[T_JAL]   = '{32'h0C00_0000, 32'h03FF_FFFF, 1, 0, 0, 0, 1, 0};
    tbl[T_JR]    = '{32'h0000_0008, 32'h03E0_0000, 1, 0, 0, 0, 0, 0};
    tbl[T_LW]    = '{32'h8C00_0000, 32'h03FF_FFFF, 0, 0, 0, 1, 1, 0};
    tbl[T_SW]    = '{32'hAC00_0000, 32'h03FF_FFFF, 0, 0, 0, 1, 0, 0};
    tbl[T_MULT]  = '{32'h0000_0018, 32'h03FF_0000, 0, 1, 0, 0, 0, 0};
    tbl[T_MFHI]  = '{32'h0000_0010, 32'h0000_F800, 0, 1, 0, 0, 1, 0};
    tbl[T_MTC0]  = '{32'h4080_0000, 32'h001F_F800, 0, 0, 1, 0, 0, 0};
    tbl[T_MFC0]  = '{32'h4000_0000, 32'h001F_F800, 0, 0, 1, 0, 1, 0};
    tbl[T_INV]   = '{32'hFC00_0000, 32'h03FF_FFFF, 0, 0, 0, 0, 0, 1};
    tbl[T_SLL]   = '{32'h0000_0000, 32'h001F_FFC0, 0, 0, 0, 0, 1, 0};

    do_reset("reset");

    // ALU pair issues together
    step(0, 2, T_ORI, T_ADDU, 0);
    peek("pair", 2, 2'b11, 2'b00, 1);
    step(0, 0, T_ORI, T_ORI, 1);

    // branch issues alone, delay slot follows next cycle
    step(0, 2, T_BEQ, T_ADDIU, 0);
    peek("branch", 2, 2'b01, 2'b00, 1);
    step(0, 0, T_ORI, T_ORI, 1);
    peek("delay", 1, 2'b01, 2'b00, 1);
    chk("delay_op", 64'(dec_instr_o[31:26]), 64'(6'b001001));
    step(0, 0, T_ORI, T_ORI, 1);

    // fill to 8, then drain two
    repeat (4) step(0, 2, T_ADDU, T_ORI, 0);
    peek("full", 8, 2'b11, 2'b00, 0);
    step(0, 0, T_ORI, T_ORI, 1);
    peek("after_pop", 6, 2'b11, 2'b00, 1);

    // occupancy 7 blocks a two-wide beat
    step(1, 0, T_ORI, T_ORI, 0);
    repeat (3) step(0, 2, T_ADDU, T_ORI, 0);
    step(0, 1, T_SLL, T_ORI, 0);
    peek("seven", 7, 2'b11, 2'b00, 0);
    step(0, 2, T_ADDU, T_ORI, 0);
    step(0, 0, T_ORI, T_ORI, 1);

    // steady push/pop at count 5 across pointer wrap
    repeat (6) step(0, 2, T_ADDU, T_ORI, 1);
    peek("steady", 5, 2'b11, 2'b00, 1);

    // flush beats push and pop
    step(0, 1, T_ADDU, T_ORI, 0);
    step(1, 2, T_ADDU, T_ORI, 1);
    peek("flush", 0, 2'b00, 2'b00, 1);

    // reserved opcode still issues, flagged, with empty control
    step(0, 2, T_INV, T_ADDU, 0);
    peek("reserved", 2, 2'b11, 2'b01, 1);
    chk("reserved_ctrl", 64'(dec_ctrl_o[CTRL_W-1:0]), 64'(0));
    step(0, 2, T_LW, T_SW, 0);
    do_reset("midreset");
    peek("post_reset", 0, 2'b00, 2'b00, 1);

    repeat (400) begin
      step($urandom_range(0, 31) == 0, $urandom_range(0, 2),
           $urandom_range(0, NT - 1), $urandom_range(0, NT - 1),
           $urandom_range(0, 2) != 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
